// File: rtl/uart_rx_buffer.sv
// Receive-side capture buffer: DEPTH-entry first-word-fall-through FIFO with
// valid/ready drain and a sticky overrun flag for words dropped while full.
module uart_rx_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clka,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overrun
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_C  = (AW+1)'(0);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wp_r;
    logic [AW-1:0]    rp_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             overrun_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == ZERO_C);
    assign pop_s   = !empty_s && rd_ready;
    // A pop in the same cycle frees a slot, so a full buffer still accepts the write.
    assign push_s  = wr_en && (!full_s || pop_s);
    assign drop_s  = wr_en && full_s && !pop_s;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clka) begin
        if (push_s) begin
            mem_r[wp_r] <= wr_data;
        end
    end

    // Pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            wp_r      <= '0;
            rp_r      <= '0;
            count_r   <= ZERO_C;
            overrun_r <= 1'b0;
        end else begin
            if (push_s) begin
                wp_r <= wp_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rp_r <= rp_r + PTR_ONE_C;
            end
            count_r <= count_nxt_s;
            // A drop wins over a simultaneous clear so no loss goes unreported.
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clr_overrun) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign rd_data  = empty_s ? {WIDTH{1'b0}} : mem_r[rp_r];
    assign rd_valid = !empty_s;
    assign count    = count_r;
    assign full     = full_s;
    assign empty    = empty_s;
    assign overrun  = overrun_r;

endmodule
